// File: rtl/wptr_full.sv
// Write-domain pointer and full-flag generator for an asynchronous FIFO.
// Advances a binary write pointer on accepted writes and publishes a
// registered Gray copy for the read-side synchronizer. From the read pointer
// already synchronized into this domain it derives registered full,
// almost_full, fill level and a sticky overflow flag. Every flag is computed
// from the next pointer, so it is correct on the same edge that moves the
// pointer.
module wptr_full #(
  parameter int ADDR_W       = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic              wclk,
  input  logic              wrst,
  input  logic              w_en,
  input  logic              ovf_clr,
  input  logic [ADDR_W:0]   g_rptr_sync,
  output logic [ADDR_W:0]   b_wptr,
  output logic [ADDR_W:0]   g_wptr,
  output logic [ADDR_W-1:0] waddr,
  output logic              wr_accept,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wlevel,
  output logic              overflow
);

  localparam logic [ADDR_W:0] AFULL_LVL = (ADDR_W + 1)'(AFULL_THRESH);

  logic              push;
  logic [ADDR_W:0]   b_wnext;
  logic [ADDR_W:0]   g_wnext;
  logic [ADDR_W:0]   r_bin;
  logic [ADDR_W:0]   level_next;
  logic              full_next;
  logic              afull_next;

  assign push      = w_en && !full;
  assign wr_accept = push;
  assign waddr     = b_wptr[ADDR_W-1:0];

  // Next-pointer arithmetic: binary increment on an accepted write and its Gray image.
  always_comb begin
    b_wnext = b_wptr + {{ADDR_W{1'b0}}, push};
    g_wnext = (b_wnext >> 1) ^ b_wnext;
  end

  // Gray-to-binary decode of the synchronized read pointer; bit i is the XOR of bits i and above.
  always_comb begin
    r_bin = '0;
    for (int i = 0; i <= ADDR_W; i++) begin
      r_bin[i] = ^(g_rptr_sync >> i);
    end
  end

  // Occupancy as seen from this domain; full means the next write pointer is one lap ahead of the read pointer.
  always_comb begin
    level_next = b_wnext - r_bin;
    afull_next = (level_next >= AFULL_LVL);
    full_next  = (g_wnext == {~g_rptr_sync[ADDR_W:ADDR_W-1], g_rptr_sync[ADDR_W-2:0]});
  end

  // Pointer and flag registers; overflow is sticky and a new overflow wins over a clear on the same edge.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      b_wptr      <= '0;
      g_wptr      <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wlevel      <= '0;
      overflow    <= 1'b0;
    end else begin
      b_wptr      <= b_wnext;
      g_wptr      <= g_wnext;
      full        <= full_next;
      almost_full <= afull_next;
      wlevel      <= level_next;
      if (w_en && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wptr_full.sv
// Self-checking bench for wptr_full with ADDR_W=3, AFULL_THRESH=6.
// A reference model predicts the registered outputs for each driven cycle and
// queues them; the entry is popped and compared after the clock edge.
module tb_wptr_full;

  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;
  localparam int THRESH = 6;

  typedef struct {
    logic [3:0] b;
    logic [3:0] g;
    logic [3:0] lvl;
    logic       full;
    logic       af;
    logic       ovf;
  } exp_t;

  logic       wclk = 1'b0;
  logic       wrst = 1'b0;
  logic       w_en = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [3:0] g_rptr_sync = '0;
  logic [3:0] b_wptr;
  logic [3:0] g_wptr;
  logic [2:0] waddr;
  logic       wr_accept;
  logic       full;
  logic       almost_full;
  logic [3:0] wlevel;
  logic       overflow;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [3:0] m_b;
  logic       m_full;
  logic       m_ovf;
  logic [3:0] m_rb;

  wptr_full #(.ADDR_W(ADDR_W), .AFULL_THRESH(THRESH)) dut (
    .wclk(wclk), .wrst(wrst), .w_en(w_en), .ovf_clr(ovf_clr),
    .g_rptr_sync(g_rptr_sync), .b_wptr(b_wptr), .g_wptr(g_wptr),
    .waddr(waddr), .wr_accept(wr_accept), .full(full),
    .almost_full(almost_full), .wlevel(wlevel), .overflow(overflow)
  );

  always #5 wclk = ~wclk;

  function automatic logic [3:0] toGray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] toBin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Drive one cycle, check combinational outputs, queue the prediction, then compare after the edge.
  task automatic applyStimulus(input logic we, input logic clr, input logic [3:0] grs);
    exp_t e;
    exp_t got;
    logic push;
    logic [3:0] nb;
    @(negedge wclk);
    w_en = we;
    ovf_clr = clr;
    g_rptr_sync = grs;
    #1;
    checkOutput("wr_accept", 32'(wr_accept), 32'(we && !m_full));
    checkOutput("waddr", 32'(waddr), 32'(m_b[2:0]));
    push  = we && !m_full;
    nb    = m_b + 4'(push);
    e.b   = nb;
    e.g   = toGray(nb);
    e.lvl = nb - toBin(grs);
    e.full = (e.lvl == 4'(DEPTH));
    e.af  = (e.lvl >= 4'(THRESH));
    e.ovf = (we && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_b = nb;
    m_full = e.full;
    m_ovf = e.ovf;
    sb.push_back(e);
    @(posedge wclk);
    #1;
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 32'(0), 32'(1));
    end else begin
      got = sb.pop_front();
      checkOutput("b_wptr", 32'(b_wptr), 32'(got.b));
      checkOutput("g_wptr", 32'(g_wptr), 32'(got.g));
      checkOutput("wlevel", 32'(wlevel), 32'(got.lvl));
      checkOutput("full", 32'(full), 32'(got.full));
      checkOutput("almost_full", 32'(almost_full), 32'(got.af));
      checkOutput("overflow", 32'(overflow), 32'(got.ovf));
    end
  endtask

  // Assert reset between edges and confirm every register clears before the next edge.
  task automatic doReset();
    @(negedge wclk);
    w_en = 1'b0;
    ovf_clr = 1'b0;
    g_rptr_sync = '0;
    #2;
    wrst = 1'b1;
    #1;
    checkOutput("rst_b_wptr", 32'(b_wptr), 32'(0));
    checkOutput("rst_g_wptr", 32'(g_wptr), 32'(0));
    checkOutput("rst_wlevel", 32'(wlevel), 32'(0));
    checkOutput("rst_full", 32'(full), 32'(0));
    checkOutput("rst_almost_full", 32'(almost_full), 32'(0));
    checkOutput("rst_overflow", 32'(overflow), 32'(0));
    m_b = '0;
    m_full = 1'b0;
    m_ovf = 1'b0;
    m_rb = '0;
    sb.delete();
    @(negedge wclk);
    wrst = 1'b0;
  endtask

  initial begin
    m_b = '0; m_full = 1'b0; m_ovf = 1'b0; m_rb = '0;
    wrst = 1'b1;
    #12;
    wrst = 1'b0;

    $display("[TB] reset after three writes");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 4'b0000);
    checkOutput("pre_rst_b_wptr", 32'(b_wptr), 32'(3));
    doReset();

    $display("[TB] fill to full");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 4'b0000);
      if (i == 5) checkOutput("af_after_6", 32'(almost_full), 32'(1));
    end
    checkOutput("fill_b_wptr", 32'(b_wptr), 32'(4'b1000));
    checkOutput("fill_g_wptr", 32'(g_wptr), 32'(4'b1100));
    checkOutput("fill_full", 32'(full), 32'(1));

    $display("[TB] overflow and clear");
    applyStimulus(1'b1, 1'b0, 4'b0000);
    applyStimulus(1'b1, 1'b0, 4'b0000);
    checkOutput("ovf_hold_ptr", 32'(b_wptr), 32'(4'b1000));
    checkOutput("ovf_set", 32'(overflow), 32'(1));
    applyStimulus(1'b1, 1'b1, 4'b0000);
    checkOutput("ovf_set_wins", 32'(overflow), 32'(1));
    applyStimulus(1'b0, 1'b1, 4'b0000);
    checkOutput("ovf_cleared", 32'(overflow), 32'(0));

    $display("[TB] drain");
    applyStimulus(1'b0, 1'b0, 4'b0010);
    checkOutput("drain_level", 32'(wlevel), 32'(5));
    applyStimulus(1'b1, 1'b0, 4'b0010);
    checkOutput("drain_af", 32'(almost_full), 32'(1));

    $display("[TB] wrap");
    applyStimulus(1'b1, 1'b0, 4'b0010);
    applyStimulus(1'b1, 1'b0, 4'b0010);
    applyStimulus(1'b1, 1'b0, 4'b0010);
    checkOutput("refull_b_wptr", 32'(b_wptr), 32'(4'b1011));
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 4'b0000);
    applyStimulus(1'b0, 1'b0, 4'b1100);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 4'b1100);
    checkOutput("wrap_b_wptr", 32'(b_wptr), 32'(0));
    checkOutput("wrap_g_wptr", 32'(g_wptr), 32'(0));
    checkOutput("wrap_level", 32'(wlevel), 32'(8));

    $display("[TB] concurrent write and read advance");
    doReset();
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 4'b0000);
    applyStimulus(1'b1, 1'b0, 4'b0001);
    checkOutput("conc_level", 32'(wlevel), 32'(7));
    checkOutput("conc_full", 32'(full), 32'(0));

    $display("[TB] random traffic");
    doReset();
    for (int i = 0; i < 200; i++) begin
      logic we;
      logic clr;
      we  = 1'($urandom_range(0, 3) != 0);
      clr = 1'($urandom_range(0, 7) == 0);
      if ((m_b != m_rb) && ($urandom_range(0, 2) == 0)) m_rb = m_rb + 4'd1;
      applyStimulus(we, clr, toGray(m_rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
